// File: rtl/mips_pkg.sv
// ---------------------------------------------------------------------------
// mips_pkg
// Shared types and constants for the MIPS fetch path.
//   fetch_state_t     : instruction-fetch FSM states
//   HALT_ADDR_DEFAULT : fetch address that marks end of program
//   RESET_VECTOR      : boot address, shared with the program counter
//   is_word_aligned() : true when an address is 32-bit aligned
// ---------------------------------------------------------------------------
package mips_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READ  = 3'd1,
    ST_HOLD  = 3'd2,
    ST_HALT  = 3'd3,
    ST_ERROR = 3'd4
  } fetch_state_t;

  localparam logic [31:0] HALT_ADDR_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] RESET_VECTOR      = 32'hBFC0_0000;

  function automatic logic is_word_aligned(input logic [31:0] addr);
    return (addr[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/mips_instr_fetch_if.sv
// ---------------------------------------------------------------------------
// mips_instr_fetch_if
// Avalon-MM read-only bus between the fetch unit and instruction memory.
//   avm_address     : read address           (master -> slave)
//   avm_read        : read strobe            (master -> slave)
//   avm_byteenable  : byte lanes, always all (master -> slave)
//   avm_waitrequest : slave stall            (slave -> master)
//   avm_readdata    : read data              (slave -> master)
// ---------------------------------------------------------------------------
interface mips_instr_fetch_if;

  logic [31:0] avm_address;
  logic        avm_read;
  logic [3:0]  avm_byteenable;
  logic        avm_waitrequest;
  logic [31:0] avm_readdata;

  modport master (
    output avm_address,
    output avm_read,
    output avm_byteenable,
    input  avm_waitrequest,
    input  avm_readdata
  );

  modport slave (
    input  avm_address,
    input  avm_read,
    input  avm_byteenable,
    output avm_waitrequest,
    output avm_readdata
  );

endinterface

// File: rtl/mips_instr_fetch.sv
// ---------------------------------------------------------------------------
// mips_instr_fetch
// Fetches one instruction per request from the Avalon-MM instruction bus,
// holds it for the controller, then pulses pc_cnt_en to advance the PC.
// Flags halt, misaligned fetch and bus timeout as sticky terminal errors.
//
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   pc           : fetch address from the program counter
//   fetch_en     : controller requests a fetch of pc
//   instr_ack    : controller consumes the held instruction
//   avm          : Avalon-MM master (address/read/byteenable/waitrequest/data)
//   instr        : captured instruction word
//   instr_valid  : instr holds an unconsumed word
//   pc_cnt_en    : one-cycle PC advance (combinational)
//   halted       : sticky, HALT_ADDR fetched
//   addr_error   : sticky, misaligned pc
//   bus_timeout  : sticky, wait limit exceeded
//
// state    | meaning
// ---------+-----------------------------------------------
// ST_IDLE  | waiting for fetch_en
// ST_READ  | Avalon read outstanding, counting stall cycles
// ST_HOLD  | instruction held until instr_ack
// ST_HALT  | HALT_ADDR fetched, stopped until reset
// ST_ERROR | misaligned fetch or bus timeout, stopped until reset
// ---------------------------------------------------------------------------
module mips_instr_fetch
  import mips_pkg::*;
#(
  parameter logic [31:0] HALT_ADDR      = HALT_ADDR_DEFAULT,
  parameter int          TIMEOUT_CYCLES = 255,
  parameter int          CNT_W          = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [31:0]               pc,
  input  logic                      fetch_en,
  input  logic                      instr_ack,
  mips_instr_fetch_if.master        avm,
  output logic [31:0]               instr,
  output logic                      instr_valid,
  output logic                      pc_cnt_en,
  output logic                      halted,
  output logic                      addr_error,
  output logic                      bus_timeout
);

  localparam bit TIMEOUT_EN = (TIMEOUT_CYCLES != 0);
  // Counter value seen on the last tolerated stall cycle.
  localparam logic [CNT_W-1:0] WAIT_LAST =
    TIMEOUT_EN ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

  fetch_state_t     state_q, state_d;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic [31:0]      addr_q, addr_d;
  logic             read_q, read_d;
  logic [31:0]      instr_q, instr_d;
  logic             valid_q, valid_d;
  logic             halted_q, halted_d;
  logic             addr_err_q, addr_err_d;
  logic             timeout_q, timeout_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      wait_cnt_q <= '0;
      addr_q     <= '0;
      read_q     <= 1'b0;
      instr_q    <= '0;
      valid_q    <= 1'b0;
      halted_q   <= 1'b0;
      addr_err_q <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      addr_q     <= addr_d;
      read_q     <= read_d;
      instr_q    <= instr_d;
      valid_q    <= valid_d;
      halted_q   <= halted_d;
      addr_err_q <= addr_err_d;
      timeout_q  <= timeout_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    addr_d     = addr_q;
    read_d     = read_q;
    instr_d    = instr_q;
    valid_d    = valid_q;
    halted_d   = halted_q;
    addr_err_d = addr_err_q;
    timeout_d  = timeout_q;

    unique case (state_q)
      ST_IDLE: begin
        if (fetch_en) begin
          // Halt check wins over alignment so a misaligned HALT_ADDR still halts.
          if (pc == HALT_ADDR) begin
            state_d  = ST_HALT;
            halted_d = 1'b1;
          end else if (!is_word_aligned(pc)) begin
            state_d    = ST_ERROR;
            addr_err_d = 1'b1;
          end else begin
            state_d    = ST_READ;
            addr_d     = pc;
            read_d     = 1'b1;
            wait_cnt_d = '0;
          end
        end
      end

      // fetch_en and pc are ignored: an issued Avalon read is never withdrawn.
      ST_READ: begin
        if (!avm.avm_waitrequest) begin
          instr_d = avm.avm_readdata;
          valid_d = 1'b1;
          read_d  = 1'b0;
          state_d = ST_HOLD;
        end else if (TIMEOUT_EN && (wait_cnt_q == WAIT_LAST)) begin
          read_d    = 1'b0;
          timeout_d = 1'b1;
          state_d   = ST_ERROR;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end

      ST_HOLD: begin
        if (instr_ack) begin
          valid_d = 1'b0;
          state_d = ST_IDLE;
        end
      end

      ST_HALT, ST_ERROR: begin
        read_d  = 1'b0;
        valid_d = 1'b0;
      end

      default: begin
        state_d = ST_IDLE;
        read_d  = 1'b0;
        valid_d = 1'b0;
      end
    endcase
  end

  // Combinational so the PC advances on the same edge instr_valid clears.
  assign pc_cnt_en = (state_q == ST_HOLD) && instr_ack;

  assign avm.avm_address    = addr_q;
  assign avm.avm_read       = read_q;
  assign avm.avm_byteenable = 4'b1111;

  assign instr       = instr_q;
  assign instr_valid = valid_q;
  assign halted      = halted_q;
  assign addr_error  = addr_err_q;
  assign bus_timeout = timeout_q;

endmodule

// File: tb/tb_mips_instr_fetch.sv
module tb_mips_instr_fetch;
  import mips_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc;
  logic        fetch_en;
  logic        instr_ack;
  logic [31:0] instr;
  logic        instr_valid, pc_cnt_en, halted, addr_error, bus_timeout;

  logic        fetch_en_to;
  logic [31:0] instr_to;
  logic        instr_valid_to, pc_cnt_en_to, halted_to, addr_error_to, bus_timeout_to;

  int n_checks = 0;
  int n_fail   = 0;

  mips_instr_fetch_if bus ();
  mips_instr_fetch_if bus_to ();

  always #5 clk = ~clk;

  mips_instr_fetch u_dut (
    .clk         (clk),
    .rst         (rst),
    .pc          (pc),
    .fetch_en    (fetch_en),
    .instr_ack   (instr_ack),
    .avm         (bus),
    .instr       (instr),
    .instr_valid (instr_valid),
    .pc_cnt_en   (pc_cnt_en),
    .halted      (halted),
    .addr_error  (addr_error),
    .bus_timeout (bus_timeout)
  );

  mips_instr_fetch #(.TIMEOUT_CYCLES(4)) u_dut_to (
    .clk         (clk),
    .rst         (rst),
    .pc          (RESET_VECTOR),
    .fetch_en    (fetch_en_to),
    .instr_ack   (instr_ack),
    .avm         (bus_to),
    .instr       (instr_to),
    .instr_valid (instr_valid_to),
    .pc_cnt_en   (pc_cnt_en_to),
    .halted      (halted_to),
    .addr_error  (addr_error_to),
    .bus_timeout (bus_timeout_to)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 2 time units after the edge.
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, ".read"},  {31'd0, bus.avm_read}, 32'd0);
    chk({tag, ".addr"},  bus.avm_address, 32'd0);
    chk({tag, ".be"},    {28'd0, bus.avm_byteenable}, 32'hF);
    chk({tag, ".instr"}, instr, 32'd0);
    chk({tag, ".flags"}, {26'd0, instr_valid, pc_cnt_en, halted, addr_error, bus_timeout, 1'b0}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int pulses;
    int rd_cycles;
    logic [31:0] addr_hold;

    rst = 1'b1; pc = RESET_VECTOR; fetch_en = 1'b0; instr_ack = 1'b0;
    fetch_en_to = 1'b0;
    bus.avm_waitrequest = 1'b0; bus.avm_readdata = 32'h0;
    bus_to.avm_waitrequest = 1'b1; bus_to.avm_readdata = 32'hDEAD_BEEF;
    step(); step();
    chk_reset_outputs("reset");
    rst = 1'b0;

    // Zero-wait fetch
    pc = 32'hBFC0_0000; fetch_en = 1'b1; instr_ack = 1'b1;
    bus.avm_readdata = 32'h2402_0005;
    step();
    chk("zw.c1.read",  {31'd0, bus.avm_read}, 32'd1);
    chk("zw.c1.addr",  bus.avm_address, 32'hBFC0_0000);
    chk("zw.c1.valid", {31'd0, instr_valid}, 32'd0);
    chk("zw.c1.cnten", {31'd0, pc_cnt_en}, 32'd0);
    fetch_en = 1'b0;
    step();
    chk("zw.c2.instr", instr, 32'h2402_0005);
    chk("zw.c2.valid", {31'd0, instr_valid}, 32'd1);
    chk("zw.c2.read",  {31'd0, bus.avm_read}, 32'd0);
    chk("zw.c2.cnten", {31'd0, pc_cnt_en}, 32'd1);
    step();
    chk("zw.c3.valid", {31'd0, instr_valid}, 32'd0);
    chk("zw.c3.cnten", {31'd0, pc_cnt_en}, 32'd0);
    chk("zw.c3.instr", instr, 32'h2402_0005);

    // Back-to-back throughput: fetch_en and ack held, one fetch per 3 cycles
    pc = 32'hBFC0_0004; bus.avm_readdata = 32'h0000_0000; fetch_en = 1'b1;
    pulses = 0;
    for (int i = 0; i < 9; i++) begin
      step();
      if (pc_cnt_en) pulses++;
    end
    fetch_en = 1'b0;
    chk("thru.pulses", pulses, 3);
    step();

    // Waitrequest stall of 3 cycles
    pc = 32'hBFC0_0010; bus.avm_readdata = 32'h8C43_0004;
    bus.avm_waitrequest = 1'b1; fetch_en = 1'b1; pulses = 0;
    step();
    fetch_en = 1'b0; pc = 32'hBFC0_0100;
    for (int i = 1; i <= 4; i++) begin
      chk($sformatf("stall.c%0d.read", i), {31'd0, bus.avm_read}, 32'd1);
      chk($sformatf("stall.c%0d.addr", i), bus.avm_address, 32'hBFC0_0010);
      chk($sformatf("stall.c%0d.valid", i), {31'd0, instr_valid}, 32'd0);
      if (pc_cnt_en) pulses++;
      if (i == 4) bus.avm_waitrequest = 1'b0;
      step();
    end
    chk("stall.valid", {31'd0, instr_valid}, 32'd1);
    chk("stall.instr", instr, 32'h8C43_0004);
    if (pc_cnt_en) pulses++;
    step();
    if (pc_cnt_en) pulses++;
    chk("stall.pulses", pulses, 1);
    chk("stall.no_timeout", {31'd0, bus_timeout}, 32'd0);

    // Backpressure: ack held low 5 cycles in HOLD
    instr_ack = 1'b0; pc = 32'hBFC0_0020; bus.avm_readdata = 32'h1111_2222;
    fetch_en = 1'b1;
    step();
    step();
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("bp.c%0d.valid", i), {31'd0, instr_valid}, 32'd1);
      chk($sformatf("bp.c%0d.instr", i), instr, 32'h1111_2222);
      chk($sformatf("bp.c%0d.cnten", i), {31'd0, pc_cnt_en}, 32'd0);
      chk($sformatf("bp.c%0d.read", i), {31'd0, bus.avm_read}, 32'd0);
      bus.avm_readdata = 32'h3333_4444 + i;
      step();
    end
    instr_ack = 1'b1; fetch_en = 1'b0;
    #1;
    chk("bp.ack.cnten", {31'd0, pc_cnt_en}, 32'd1);
    step();
    chk("bp.after.valid", {31'd0, instr_valid}, 32'd0);
    chk("bp.after.cnten", {31'd0, pc_cnt_en}, 32'd0);

    // Reset mid-READ
    pc = 32'hBFC0_0030; bus.avm_waitrequest = 1'b1; fetch_en = 1'b1; instr_ack = 1'b1;
    step();
    chk("rstrd.read", {31'd0, bus.avm_read}, 32'd1);
    rst = 1'b1; fetch_en = 1'b0; bus.avm_waitrequest = 1'b0;
    bus.avm_readdata = 32'hAAAA_5555;
    step();
    chk_reset_outputs("rstrd");
    rst = 1'b0;
    pc = 32'hBFC0_0008; bus.avm_readdata = 32'h0C10_0040; fetch_en = 1'b1;
    step();
    fetch_en = 1'b0;
    chk("rstrd.re.addr", bus.avm_address, 32'hBFC0_0008);
    chk("rstrd.re.read", {31'd0, bus.avm_read}, 32'd1);
    step();
    chk("rstrd.re.instr", instr, 32'h0C10_0040);
    chk("rstrd.re.cnten", {31'd0, pc_cnt_en}, 32'd1);
    step();

    // Misaligned fetch
    pc = 32'hBFC0_0002; fetch_en = 1'b1;
    step();
    chk("mis.addr_error", {31'd0, addr_error}, 32'd1);
    chk("mis.read", {31'd0, bus.avm_read}, 32'd0);
    chk("mis.halted", {31'd0, halted}, 32'd0);
    pc = 32'hBFC0_0004;
    step();
    chk("mis.sticky", {31'd0, addr_error}, 32'd1);
    chk("mis.still_no_read", {31'd0, bus.avm_read}, 32'd0);
    fetch_en = 1'b0;

    // Halt
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("halt.pre_rst_clear", {31'd0, addr_error}, 32'd0);
    pc = 32'h0000_0000; fetch_en = 1'b1;
    step();
    chk("halt.halted", {31'd0, halted}, 32'd1);
    chk("halt.read", {31'd0, bus.avm_read}, 32'd0);
    pc = 32'hBFC0_0000;
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("halt.sticky%0d", i), {31'd0, halted}, 32'd1);
      chk($sformatf("halt.noread%0d", i), {31'd0, bus.avm_read}, 32'd0);
      chk($sformatf("halt.cnten%0d", i), {31'd0, pc_cnt_en}, 32'd0);
    end
    fetch_en = 1'b0;

    // Bus timeout on the TIMEOUT_CYCLES=4 instance, waitrequest stuck high
    fetch_en_to = 1'b1;
    step();
    fetch_en_to = 1'b0;
    rd_cycles = 0;
    for (int i = 0; i < 20; i++) begin
      if (!bus_to.avm_read) break;
      rd_cycles++;
      chk("to.no_early_flag", {31'd0, bus_timeout_to}, 32'd0);
      step();
    end
    chk("to.read_cycles", rd_cycles, 4);
    chk("to.flag", {31'd0, bus_timeout_to}, 32'd1);
    step();
    chk("to.read_after", {31'd0, bus_to.avm_read}, 32'd0);
    chk("to.sticky", {31'd0, bus_timeout_to}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
